// File: rtl/pic32_spi_slave.sv
// Mode-0 SPI slave giving the PIC32 and the Nios (Avalon-MM) shared access to a 32-bit mailbox bank.
// Define PIC32_SPI_AUTOINC_EN for multi-word bursts with an auto-incrementing address.
module pic32_spi_slave #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic              spi_sint,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);
    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, CMD, DATA, COMMIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [31:0]            shift_q, shift_d;
    logic [31:0]            shadow_q, shadow_d;
    logic                   rw_q, rw_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   sdo_q, sdo_d;
    logic                   sint_q, sint_d;
    logic                   irq_q, irq_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            regs_q [NREGS];
    logic [31:0]            regs_d [NREGS];

    logic        sclk_s, cs_s, sdi_s, rise, fall, cs_fall, commit_en;
    logic [31:0] sdi_word;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
    end

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_prev_q;
    assign fall     = ~sclk_s & sclk_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign sdi_word = {shift_q[30:0], sdi_s};
    assign commit_en = (state_q == COMMIT);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        sdo_d     = sdo_q;
        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                sdo_d = 1'b0;
                if (cs_s) begin
                    state_d = IDLE;
                end else if (rise) begin
                    shift_d   = sdi_word;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        rw_d      = sdi_word[7];
                        addr_d    = sdi_word[ADDR_W-1:0];
                        shadow_d  = regs_q[sdi_word[ADDR_W-1:0]];
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_s) begin
                    state_d = IDLE;
                    sdo_d   = 1'b0;
                end else begin
                    if (fall && !rw_q) begin
                        sdo_d    = shadow_q[31];
                        shadow_d = {shadow_q[30:0], 1'b0};
                    end
                    if (rise) begin
                        shift_d   = sdi_word;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd31) begin
                            bit_cnt_d = '0;
                            state_d   = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
`ifdef PIC32_SPI_AUTOINC_EN
                // Next word of the burst; reload the shadow before its first fall.
                addr_d  = addr_q + 1'b1;
                state_d = DATA;
                if (!rw_q) begin
                    shadow_d = regs_q[addr_q + 1'b1];
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                sdo_d = 1'b0;
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ordering gives Avalon writes priority over SPI commits, and sets priority over clears.
    always_comb begin
        regs_d  = regs_q;
        sint_d  = sint_q;
        irq_d   = irq_q;
        rdata_d = rdata_q;
        if (commit_en) begin
            if (rw_q) begin
                regs_d[addr_q] = shift_q;
            end else if (addr_q == '0) begin
                sint_d = 1'b0;
            end
        end
        if (avs_read) begin
            rdata_d = regs_q[avs_address];
            if (avs_address == ADDR_W'(1)) begin
                irq_d = 1'b0;
            end
        end
        if (commit_en && rw_q && addr_q == ADDR_W'(1)) begin
            irq_d = 1'b1;
        end
        if (avs_write) begin
            regs_d[avs_address] = avs_writedata;
            if (avs_address == '0) begin
                sint_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sdo_q       <= 1'b0;
            sint_q      <= 1'b0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            sdo_q       <= sdo_d;
            sint_q      <= sint_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            regs_q      <= regs_d;
        end
    end

    always_ff @(posedge clk) begin
        sdi_sync_q <= sdi_sync_d;
        shift_q    <= shift_d;
        shadow_q   <= shadow_d;
        rw_q       <= rw_d;
        addr_q     <= addr_d;
    end

    assign spi_sdo      = sdo_q;
    assign spi_sdo_oe   = ~cs_s;
    assign spi_sint     = sint_q;
    assign irq          = irq_q;
    assign avs_readdata = rdata_q;
endmodule

// File: tb/tb_pic32_spi_slave.sv
// Directed bench for pic32_spi_slave: SPI master model at SCK = clk/8 plus Avalon accesses,
// with expected read data queued when a read is issued and checked when it returns.
module tb_pic32_spi_slave;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              spi_sclk, spi_cs, spi_sdi;
    logic              spi_sdo, spi_sdo_oe, spi_sint;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read, avs_write;
    logic [31:0]       avs_writedata, avs_readdata;
    logic              irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [31:0] rx;
    logic        oem;

    always #5 clk = ~clk;

    pic32_spi_slave #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .spi_sint(spi_sint),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
            end
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic avs_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        avs_address = a;
        avs_read    = 1'b1;
        tick(1);
        avs_read = 1'b0;
        sb_pop(avs_readdata);
    endtask

    // mode 0: plain frame; 1: Avalon read of addr 1 in the commit cycle;
    // 2: Avalon write of addr 5 in the commit cycle; 3: assert reset after the last bit, cs left low.
    task automatic spi_frame(input logic [135:0] bits, input int nbits, input int mode,
                             output logic [31:0] rxd, output logic oe_mid);
        rxd    = '0;
        oe_mid = 1'b0;
        spi_cs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b0;
            spi_sdi  = bits[135-i];
            tick(4);
            if (i == 20) oe_mid = spi_sdo_oe;
            if (i >= 8) rxd = {rxd[30:0], spi_sdo};
            spi_sclk = 1'b1;
            if (i == nbits - 1 && (mode == 1 || mode == 2)) begin
                // Rise seen after two sync stages, COMMIT the cycle after: strobe lands on the commit edge.
                tick(3);
                if (mode == 1) begin
                    avs_address = ADDR_W'(1);
                    avs_read    = 1'b1;
                end else begin
                    avs_address   = ADDR_W'(5);
                    avs_writedata = 32'h0000BBBB;
                    avs_write     = 1'b1;
                end
                tick(1);
                avs_read  = 1'b0;
                avs_write = 1'b0;
                tick(3);
            end else begin
                tick(4);
            end
        end
        if (mode == 3) begin
            reset = 1'b1;
            tick(1);
        end else begin
            spi_sclk = 1'b0;
            tick(4);
            spi_cs = 1'b1;
            tick(6);
        end
    endtask

    initial begin
        reset = 1'b1;
        spi_sclk = 1'b0; spi_cs = 1'b1; spi_sdi = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        tick(3);
        reset = 1'b0;
        tick(2);
        check("rst_sdo", 32'(spi_sdo), 32'd0);
        check("rst_oe", 32'(spi_sdo_oe), 32'd0);
        check("rst_sint", 32'(spi_sint), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);

        spi_frame({8'h82, 32'hDEADBEEF, 96'd0}, 40, 0, rx, oem);
        check("wr2_irq", 32'(irq), 32'd0);
        avs_rd("avs_rd2", ADDR_W'(2), 32'hDEADBEEF);

        avs_wr(ADDR_W'(3), 32'h12345678);
        sb_push("spi_rd3", 32'h12345678);
        spi_frame({8'h03, 128'd0}, 40, 0, rx, oem);
        sb_pop(rx);
        check("oe_mid_frame", 32'(oem), 32'd1);
        check("oe_after_cs", 32'(spi_sdo_oe), 32'd0);

        avs_wr(ADDR_W'(0), 32'h1);
        tick(1);
        check("sint_set", 32'(spi_sint), 32'd1);
        sb_push("spi_rd0", 32'h00000001);
        spi_frame({8'h00, 128'd0}, 40, 0, rx, oem);
        sb_pop(rx);
        check("sint_cleared", 32'(spi_sint), 32'd0);
        avs_wr(ADDR_W'(0), 32'h1);
        spi_frame({8'h00, 128'd0}, 20, 0, rx, oem);
        check("sint_abort_kept", 32'(spi_sint), 32'd1);

        spi_frame({8'h81, 32'h000000A5, 96'd0}, 40, 0, rx, oem);
        check("irq_set", 32'(irq), 32'd1);
        avs_rd("avs_rd1", ADDR_W'(1), 32'h000000A5);
        check("irq_cleared", 32'(irq), 32'd0);
        spi_frame({8'h81, 32'h0000005A, 96'd0}, 40, 1, rx, oem);
        check("irq_set_wins", 32'(irq), 32'd1);
        avs_rd("avs_rd1_b", ADDR_W'(1), 32'h0000005A);
        check("irq_cleared_b", 32'(irq), 32'd0);

        spi_frame({8'h85, 32'hAAAA0000, 96'd0}, 40, 2, rx, oem);
        avs_rd("avs_wins_rd5", ADDR_W'(5), 32'h0000BBBB);

        spi_frame({8'h84, 32'hCAFEF00D, 96'd0}, 30, 0, rx, oem);
        avs_rd("abort_rd4", ADDR_W'(4), 32'h0);

        spi_frame({8'h81, 32'h00000001, 96'd0}, 40, 0, rx, oem);
        avs_rd("pre_rst_rd2", ADDR_W'(2), 32'hDEADBEEF);
        spi_frame({8'h03, 128'd0}, 20, 3, rx, oem);
        check("midrst_sdo", 32'(spi_sdo), 32'd0);
        check("midrst_oe", 32'(spi_sdo_oe), 32'd0);
        check("midrst_sint", 32'(spi_sint), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_rdata", avs_readdata, 32'd0);
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        check("post_rst_oe", 32'(spi_sdo_oe), 32'd0);
        avs_rd("post_rst_rd2", ADDR_W'(2), 32'h0);
        avs_rd("post_rst_rd3", ADDR_W'(3), 32'h0);

`ifdef PIC32_SPI_AUTOINC_EN
        spi_frame({8'h86, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0}, 104, 0, rx, oem);
        avs_rd("burst_rd6", ADDR_W'(6), 32'h11111111);
        avs_rd("burst_rd7", ADDR_W'(7), 32'h22222222);
        avs_rd("burst_wrap_rd0", ADDR_W'(0), 32'h33333333);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
